macro_active_ctrl: RTL

MACRO_ACTIVE_CTRL -- requirements
Module: macro_active_ctrl

---
 rtl/macro_active_ctrl.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/macro_active_ctrl.sv
// Wishbone-controlled io_active sequencer for up to four macros.
// Every change of enabled macro passes through a 2-cycle all-off guard gap.
module macro_active_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          N_MACRO   = 4
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_n,
  input  logic               wbs_stb_i,
  input  logic               wbs_cyc_i,
  input  logic               wbs_we_i,
  input  logic [3:0]         wbs_sel_i,
  input  logic [31:0]        wbs_adr_i,
  input  logic [31:0]        wbs_dat_i,
  output logic               wbs_ack_o,
  output logic [31:0]        wbs_dat_o,
  output logic [N_MACRO-1:0] io_active,
  output logic               scan_irq
);

  typedef enum logic [1:0] {IDLE, GUARD, ACTIVE} state_t;

  state_t      state_q, state_d;
  logic [1:0]  rst_sync;
  logic        run_ok;
  logic        hit, accept, wr, wr_ctrl, wr_dwell, wr_mask;
  logic [1:0]  reg_idx;
  logic        en_q, auto_q, err_q;
  logic [1:0]  sel_q;
  logic [15:0] dwell_q;
  logic [3:0]  mask_q;
  logic        en_n, auto_n;
  logic [1:0]  sel_n;
  logic [15:0] dwell_n;
  logic [3:0]  mask_n;
  logic [1:0]  cur_idx_q, cur_idx_d, nxt_idx, load_idx;
  logic        guard_q, guard_d;
  logic [15:0] dwell_cnt_q, dwell_cnt_d;
  logic [7:0]  scan_cnt_q;
  logic        advance, wrap_d;
  logic [31:0] rdata;
  logic        unused_bits;

  // Next set mask bit strictly after cur, ascending with wrap; cur itself if it is the only one.
  function automatic logic [1:0] next_set(input logic [3:0] m, input logic [1:0] cur);
    logic [1:0] pick;
    pick = cur;
    for (int i = 3; i >= 1; i--) begin
      if (m[cur + 2'(i)]) pick = cur + 2'(i);
    end
    return pick;
  endfunction

  assign unused_bits = ^{wbs_adr_i[1:0], wbs_dat_i[31:16]};

  assign run_ok   = rst_sync[1];
  assign hit      = wbs_stb_i && wbs_cyc_i && (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign accept   = hit && !wbs_ack_o;
  assign reg_idx  = wbs_adr_i[3:2];
  assign wr       = accept && wbs_we_i;
  assign wr_ctrl  = wr && (reg_idx == 2'd0) && wbs_sel_i[0];
  assign wr_dwell = wr && (reg_idx == 2'd1);
  assign wr_mask  = wr && (reg_idx == 2'd3) && wbs_sel_i[0];

  // The FSM reacts to register writes in the same cycle they are accepted.
  assign en_n          = wr_ctrl ? wbs_dat_i[0]   : en_q;
  assign auto_n        = wr_ctrl ? wbs_dat_i[1]   : auto_q;
  assign sel_n         = wr_ctrl ? wbs_dat_i[3:2] : sel_q;
  assign dwell_n[7:0]  = (wr_dwell && wbs_sel_i[0]) ? wbs_dat_i[7:0]  : dwell_q[7:0];
  assign dwell_n[15:8] = (wr_dwell && wbs_sel_i[1]) ? wbs_dat_i[15:8] : dwell_q[15:8];
  assign mask_n        = wr_mask ? wbs_dat_i[3:0] : mask_q;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) rst_sync <= 2'b00;
    else           rst_sync <= {rst_sync[0], 1'b1};
  end

  always_comb begin
    rdata = '0;
    case (reg_idx)
      2'd0:    rdata[3:0]  = {sel_q, auto_q, en_q};
      2'd1:    rdata[15:0] = dwell_q;
      2'd2:    rdata[15:0] = {scan_cnt_q, 4'h0, err_q, state_q == ACTIVE, cur_idx_q};
      default: rdata[3:0]  = mask_q;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      en_q      <= 1'b0;
      auto_q    <= 1'b0;
      sel_q     <= 2'd0;
      dwell_q   <= 16'h0010;
      mask_q    <= 4'hF;
      err_q     <= 1'b0;
    end else begin
      wbs_ack_o <= accept;
      wbs_dat_o <= (accept && !wbs_we_i) ? rdata : '0;
      en_q      <= en_n;
      auto_q    <= auto_n;
      sel_q     <= sel_n;
      dwell_q   <= dwell_n;
      mask_q    <= mask_n;
      err_q     <= auto_n && (mask_n == 4'h0);
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q     <= IDLE;
      cur_idx_q   <= 2'd0;
      guard_q     <= 1'b0;
      dwell_cnt_q <= 16'd0;
      scan_cnt_q  <= 8'd0;
      scan_irq    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_idx_q   <= cur_idx_d;
      guard_q     <= guard_d;
      dwell_cnt_q <= dwell_cnt_d;
      scan_irq    <= wrap_d;
      if (wrap_d) scan_cnt_q <= scan_cnt_q + 8'd1;
    end
  end

  // Priority: shutdown, start-up, mode/selection changes, mask loss, guard timing, dwell expiry.
  always_comb begin
    state_d     = state_q;
    cur_idx_d   = cur_idx_q;
    guard_d     = guard_q;
    dwell_cnt_d = dwell_cnt_q;
    advance     = 1'b0;
    wrap_d      = 1'b0;
    nxt_idx     = next_set(mask_n, cur_idx_q);
    load_idx    = auto_n ? next_set(mask_n, 2'd3) : sel_n;
    if (!run_ok || !en_n || (auto_n && (mask_n == 4'h0))) begin
      state_d = IDLE;
    end else if (state_q == IDLE || auto_n != auto_q) begin
      state_d   = GUARD;
      cur_idx_d = load_idx;
      guard_d   = 1'b0;
    end else if (!auto_n && wr_ctrl && (sel_n != sel_q)) begin
      state_d   = GUARD;
      cur_idx_d = sel_n;
      guard_d   = 1'b0;
    end else if (auto_n && !mask_n[cur_idx_q]) begin
      advance = 1'b1;
    end else if (state_q == GUARD) begin
      if (guard_q) begin
        state_d     = ACTIVE;
        dwell_cnt_d = (dwell_n == 16'd0) ? 16'd1 : dwell_n;
      end else begin
        guard_d = 1'b1;
      end
    end else if (auto_n && !wr_ctrl) begin
      if (dwell_cnt_q <= 16'd1) advance = 1'b1;
      else                      dwell_cnt_d = dwell_cnt_q - 16'd1;
    end
    if (advance) begin
      state_d   = GUARD;
      cur_idx_d = nxt_idx;
      guard_d   = 1'b0;
      wrap_d    = (nxt_idx <= cur_idx_q);
    end
  end

  always_comb begin
    io_active = '0;
    if (state_q == ACTIVE) io_active[cur_idx_q] = 1'b1;
  end

endmodule
